// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM stage: data-memory access FSM and MEM/WB register.
// Optional MEM_TIMEOUT_EN adds an ACCESS-state timeout that raises BusErr.
module mem_access_unit #(
  parameter logic [3:0] TIMEOUT = 4'd15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic        RegWr,
  input  logic [1:0]  MemToReg,
  input  logic [31:0] ALUResult,
  input  logic [31:0] ReadData2,
  input  logic [31:0] NextPC,
  input  logic [4:0]  RegDst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        Stall,
  output logic        AddrErr,
  output logic        BusErr,
  output logic        oRegWr,
  output logic [1:0]  oMemToReg,
  output logic [31:0] oALUResult,
  output logic [31:0] oMemData,
  output logic [4:0]  oRegDst,
  output logic [31:0] oNextPC
);
  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t      state, state_next;
  logic        mem_op, aligned, start, timeout_hit, we_l;
  logic [31:0] addr_l, wdata_l;

  assign mem_op  = MemRd | MemWr;
  assign aligned = (ALUResult[1:0] == 2'b00);
  assign start   = (state == IDLE) && mem_op && aligned;

`ifdef MEM_TIMEOUT_EN
  logic [3:0] tcount;
  assign timeout_hit = (state == ACCESS) && !mem_ready && (tcount == TIMEOUT - 4'd1);

  always_ff @(posedge clk) begin
    if (reset)
      tcount <= 4'd0;
    else if (start)
      tcount <= 4'd0;
    else if (state == ACCESS && !mem_ready)
      tcount <= tcount + 4'd1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mem_op && aligned) state_next = ACCESS;
      ACCESS:  if (mem_ready || timeout_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Reset forces every strobe low, abandoning any in-flight request.
  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    Stall   = 1'b0;
    AddrErr = 1'b0;
    BusErr  = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          Stall   = mem_op && aligned;
          AddrErr = mem_op && !aligned;
        end
        ACCESS: begin
          mem_req = 1'b1;
          mem_we  = we_l;
          Stall   = !mem_ready && !timeout_hit;
          BusErr  = timeout_hit;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = addr_l;
  assign mem_wdata = wdata_l;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_l     <= 32'd0;
      wdata_l    <= 32'd0;
      we_l       <= 1'b0;
      oRegWr     <= 1'b0;
      oMemToReg  <= 2'd0;
      oALUResult <= 32'd0;
      oMemData   <= 32'd0;
      oRegDst    <= 5'd0;
      oNextPC    <= 32'd0;
    end else begin
      if (start) begin
        addr_l  <= ALUResult;
        wdata_l <= ReadData2;
        we_l    <= MemWr;
      end
      // A stalled edge inserts a bubble by only killing the write enable.
      if (Stall) begin
        oRegWr <= 1'b0;
      end else begin
        oRegWr     <= RegWr && !AddrErr && !BusErr;
        oMemToReg  <= MemToReg;
        oALUResult <= ALUResult;
        oMemData   <= (state == ACCESS && mem_ready && !we_l) ? mem_rdata : 32'd0;
        oRegDst    <= RegDst;
        oNextPC    <= NextPC;
      end
    end
  end
endmodule
